// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Bit counter width: enough to count 0..width-1, never narrower than one bit.
    function automatic int counterWidth(input int width);
        if (width <= 2) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operation handshake and operand/result bus for the serial adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder; the only arithmetic element of the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flip-flop process
// the operands LSB-first, one bit per clock, framed by a start/busy/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int             CNT_W    = counterWidth(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e state_q, state_d;

    logic [WIDTH-1:0] aShift_q, aShift_d;
    logic [WIDTH-1:0] bShift_q, bShift_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
    logic             carry_q,  carry_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    logic cellS;
    logic cellCo;
    logic lastBit;
    logic accept;
    logic msbCarryIn;
    logic busy;
    logic done;

    // A new operation may only be taken while no bits are in flight.
    assign accept     = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign lastBit    = (state_q == RUN) && (bitCnt_q == LAST_BIT);
    // On the final bit the carry FF still holds the carry into the MSB.
    assign msbCarryIn = carry_q;

    fa_cell u_fa_cell (
        .a  (aShift_q[0]),
        .b  (bShift_q[0]),
        .ci (carry_q),
        .s  (cellS),
        .co (cellCo)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RUN for WIDTH cycles, one DONE cycle, restart allowed from DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? RUN : IDLE;
            RUN:     state_d = (bitCnt_q == LAST_BIT) ? DONE : RUN;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode of the registered state; start has no path to busy/done.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: load on accept, shift one bit per RUN cycle, publish on the last bit.
    always_comb begin
        aShift_d = aShift_q;
        bShift_d = bShift_q;
        res_d    = res_q;
        sum_d    = sum_q;
        bitCnt_d = bitCnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        if (accept) begin
            aShift_d = bus.a;
            bShift_d = bus.sub ? ~bus.b : bus.b;
            carry_d  = bus.sub ? ~bus.cin : bus.cin;
            bitCnt_d = '0;
        end else if (state_q == RUN) begin
            aShift_d = aShift_q >> 1;
            bShift_d = bShift_q >> 1;
            res_d    = {cellS, res_q[WIDTH-1:1]};
            carry_d  = cellCo;
            bitCnt_d = bitCnt_q + CNT_W'(1);
            if (lastBit) begin
                sum_d  = {cellS, res_q[WIDTH-1:1]};
                cout_d = cellCo;
                ovf_d  = cellCo ^ msbCarryIn;
            end
        end
    end

    // Datapath registers, all cleared by reset so an aborted operation leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aShift_q <= '0;
            bShift_q <= '0;
            res_q    <= '0;
            sum_q    <= '0;
            bitCnt_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            aShift_q <= aShift_d;
            bShift_q <= bShift_d;
            res_q    <= res_d;
            sum_q    <= sum_d;
            bitCnt_q <= bitCnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases, random operations,
// back-to-back streaming, mid-run reset and an exhaustive WIDTH=2 sweep.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(2)) bus2 ();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // Reference: true unsigned/signed arithmetic, reduced modulo 2^w.
    function automatic void refModel(input int w, input logic [7:0] a, input logic [7:0] b,
                                     input logic cin, input logic sub,
                                     output logic [7:0] s, output logic c, output logic o);
        longint m, ua, ub, sa, sb, tot, st;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (!sub) begin
            tot = ua + ub + longint'(cin);
            c   = (tot >= m);
            st  = sa + sb + longint'(cin);
        end else begin
            tot = ua - ub - longint'(cin);
            c   = (ua >= ub + longint'(cin));
            st  = sa - sb - longint'(cin);
        end
        s = 8'(tot & (m - 1));
        o = (st < -(m / 2)) || (st > m / 2 - 1);
    endfunction

    // Runs one WIDTH=8 operation and reports what was observed.
    task automatic doOp8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                         output int lat, output logic [7:0] s, output logic c, output logic o,
                         output logic busyAtStart, output logic doneAfter);
        @(posedge clk); #1;
        bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start  = 1'b0;
        busyAtStart = bus8.busy;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus8.done) begin
                lat = i;
                break;
            end
        end
        s = bus8.sum; c = bus8.cout; o = bus8.ovf;
        @(posedge clk); #1;
        doneAfter = bus8.done;
    endtask

    // Runs one WIDTH=2 operation and reports what was observed.
    task automatic doOp2(input logic [1:0] a, input logic [1:0] b, input logic cin, input logic sub,
                         output int lat, output logic [1:0] s, output logic c, output logic o);
        @(posedge clk); #1;
        bus2.a = a; bus2.b = b; bus2.cin = cin; bus2.sub = sub; bus2.start = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (bus2.done) begin
                lat = i;
                break;
            end
        end
        s = bus2.sum; c = bus2.cout; o = bus2.ovf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus8.start = 0; bus8.sub = 0; bus8.cin = 0; bus8.a = '0; bus8.b = '0;
        bus2.start = 0; bus2.sub = 0; bus2.cin = 0; bus2.a = '0; bus2.b = '0;
        repeat (3) @(posedge clk);
        #1;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf} !== 12'h000) begin
            mismatched++;
            $display("[TB] FAIL reset_w8: got %h expected 000",
                     {bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf});
        end
        compared++;
        if ({bus2.busy, bus2.done, bus2.sum, bus2.cout, bus2.ovf} !== 6'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_w2: got %h expected 00",
                     {bus2.busy, bus2.done, bus2.sum, bus2.cout, bus2.ovf});
        end
        compared++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if ({bus8.busy, bus8.done} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL idle_after_reset: got %b expected 00", {bus8.busy, bus8.done});
        end
        compared++;
    endtask

    task automatic test_add();
        int lat; logic [7:0] s; logic c, o, bs, da;
        doOp8(8'h3C, 8'h5A, 1'b0, 1'b0, lat, s, c, o, bs, da);
        if (bs !== 1'b1) begin mismatched++; $display("[TB] FAIL add_busy: got %b expected 1", bs); end
        compared++;
        if (lat !== 8) begin mismatched++; $display("[TB] FAIL add_latency: got %0d expected 8", lat); end
        compared++;
        if ({s, c, o} !== {8'h96, 1'b0, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL add_result: got sum=%h cout=%b ovf=%b expected sum=96 cout=0 ovf=1", s, c, o);
        end
        compared++;
        if (da !== 1'b0) begin mismatched++; $display("[TB] FAIL add_done_width: got %b expected 0", da); end
        compared++;
    endtask

    task automatic test_add_wrap();
        int lat; logic [7:0] s; logic c, o, bs, da;
        doOp8(8'hFF, 8'h01, 1'b1, 1'b0, lat, s, c, o, bs, da);
        if ({s, c, o} !== {8'h01, 1'b1, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL add_wrap: got sum=%h cout=%b ovf=%b expected sum=01 cout=1 ovf=0", s, c, o);
        end
        compared++;
    endtask

    task automatic test_sub();
        int lat; logic [7:0] s; logic c, o, bs, da;
        doOp8(8'h10, 8'h01, 1'b0, 1'b1, lat, s, c, o, bs, da);
        if ({s, c} !== {8'h0F, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL sub_basic: got sum=%h cout=%b expected sum=0f cout=1", s, c);
        end
        compared++;
        doOp8(8'h00, 8'h01, 1'b0, 1'b1, lat, s, c, o, bs, da);
        if ({s, c, o} !== {8'hFF, 1'b0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL sub_borrow: got sum=%h cout=%b ovf=%b expected sum=ff cout=0 ovf=0", s, c, o);
        end
        compared++;
        doOp8(8'h80, 8'h01, 1'b0, 1'b1, lat, s, c, o, bs, da);
        if ({s, c, o} !== {8'h7F, 1'b1, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL sub_ovf: got sum=%h cout=%b ovf=%b expected sum=7f cout=1 ovf=1", s, c, o);
        end
        compared++;
    endtask

    task automatic test_ignore_start();
        int lat, extra;
        logic [7:0] es; logic ec, eo;
        refModel(8, 8'h21, 8'h43, 1'b1, 1'b0, es, ec, eo);
        @(posedge clk); #1;
        bus8.a = 8'h21; bus8.b = 8'h43; bus8.cin = 1'b1; bus8.sub = 1'b0; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        bus8.a = 8'hEE; bus8.b = 8'h77; bus8.cin = 1'b0; bus8.sub = 1'b1; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        lat = -1;
        for (int i = 4; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus8.done) begin
                lat = i;
                break;
            end
        end
        if (lat !== 8) begin mismatched++; $display("[TB] FAIL ignore_latency: got %0d expected 8", lat); end
        compared++;
        if ({bus8.sum, bus8.cout, bus8.ovf} !== {es, ec, eo}) begin
            mismatched++;
            $display("[TB] FAIL ignore_result: got %h/%b/%b expected %h/%b/%b",
                     bus8.sum, bus8.cout, bus8.ovf, es, ec, eo);
        end
        compared++;
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus8.done || bus8.busy) extra++;
        end
        if (extra !== 0) begin mismatched++; $display("[TB] FAIL ignore_no_extra: got %0d active cycles expected 0", extra); end
        compared++;
    endtask

    task automatic test_random();
        logic [7:0] a, b, es, ps; logic cin, sub, ec, eo, pc, po, prevValid;
        int lat;
        prevValid = 1'b0;
        ps = '0; pc = 1'b0; po = 1'b0;
        for (int n = 0; n < 24; n++) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            refModel(8, a, b, cin, sub, es, ec, eo);
            @(posedge clk); #1;
            bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub; bus8.start = 1'b1;
            @(posedge clk); #1;
            bus8.start = 1'b0;
            lat = -1;
            for (int i = 1; i <= 20; i++) begin
                @(posedge clk); #1;
                if (bus8.done) begin
                    lat = i;
                    break;
                end
                if (prevValid) begin
                    if ({bus8.sum, bus8.cout, bus8.ovf} !== {ps, pc, po}) begin
                        mismatched++;
                        $display("[TB] FAIL rand_hold: got %h/%b/%b expected %h/%b/%b",
                                 bus8.sum, bus8.cout, bus8.ovf, ps, pc, po);
                    end
                    compared++;
                end
            end
            if (lat !== 8) begin mismatched++; $display("[TB] FAIL rand_latency: got %0d expected 8", lat); end
            compared++;
            if ({bus8.sum, bus8.cout, bus8.ovf} !== {es, ec, eo}) begin
                mismatched++;
                $display("[TB] FAIL rand_result: a=%h b=%h cin=%b sub=%b got %h/%b/%b expected %h/%b/%b",
                         a, b, cin, sub, bus8.sum, bus8.cout, bus8.ovf, es, ec, eo);
            end
            compared++;
            ps = es; pc = ec; po = eo; prevValid = 1'b1;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ca, cb, es; logic ccin, csub, ec, eo;
        @(posedge clk); #1;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom); bus8.sub = 1'($urandom);
        bus8.start = 1'b1;
        @(posedge clk); #1;
        ca = bus8.a; cb = bus8.b; ccin = bus8.cin; csub = bus8.sub;
        if ({bus8.busy, bus8.done} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL b2b_first_accept: got %b expected 10", {bus8.busy, bus8.done});
        end
        compared++;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom); bus8.sub = 1'($urandom);
        for (int r = 0; r < 4; r++) begin
            refModel(8, ca, cb, ccin, csub, es, ec, eo);
            for (int k = 1; k <= 8; k++) begin
                @(posedge clk); #1;
                if ({bus8.busy, bus8.done} !== {(k < 8), (k == 8)}) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_handshake: op %0d cycle %0d got %b expected %b",
                             r, k, {bus8.busy, bus8.done}, {(k < 8), (k == 8)});
                end
                compared++;
            end
            if ({bus8.sum, bus8.cout, bus8.ovf} !== {es, ec, eo}) begin
                mismatched++;
                $display("[TB] FAIL b2b_result: op %0d got %h/%b/%b expected %h/%b/%b",
                         r, bus8.sum, bus8.cout, bus8.ovf, es, ec, eo);
            end
            compared++;
            ca = bus8.a; cb = bus8.b; ccin = bus8.cin; csub = bus8.sub;
            if (r < 3) begin
                @(posedge clk); #1;
                bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom); bus8.sub = 1'($urandom);
            end else begin
                bus8.start = 1'b0;
                @(posedge clk); #1;
                if ({bus8.busy, bus8.done} !== 2'b00) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_stop: got %b expected 00", {bus8.busy, bus8.done});
                end
                compared++;
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, seen; logic [7:0] s; logic c, o, bs, da;
        doOp8(8'h3C, 8'h5A, 1'b0, 1'b0, lat, s, c, o, bs, da);
        @(posedge clk); #1;
        bus8.a = 8'h55; bus8.b = 8'h66; bus8.cin = 1'b1; bus8.sub = 1'b0; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf} !== 12'h000) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_run: got %h expected 000",
                     {bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf});
        end
        compared++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus8.done || bus8.busy) seen++;
        end
        if (seen !== 0) begin mismatched++; $display("[TB] FAIL reset_no_done: got %0d active cycles expected 0", seen); end
        compared++;
    endtask

    task automatic test_exhaustive_w2();
        int lat; logic [1:0] s; logic c, o; logic [7:0] es; logic ec, eo;
        for (int sb = 0; sb < 2; sb++) begin
            for (int ci = 0; ci < 2; ci++) begin
                for (int av = 0; av < 4; av++) begin
                    for (int bv = 0; bv < 4; bv++) begin
                        refModel(2, 8'(av), 8'(bv), 1'(ci), 1'(sb), es, ec, eo);
                        doOp2(2'(av), 2'(bv), 1'(ci), 1'(sb), lat, s, c, o);
                        if (lat !== 2) begin
                            mismatched++;
                            $display("[TB] FAIL w2_latency: got %0d expected 2", lat);
                        end
                        compared++;
                        if ({s, c, o} !== {es[1:0], ec, eo}) begin
                            mismatched++;
                            $display("[TB] FAIL w2_result: a=%0d b=%0d cin=%0d sub=%0d got %b/%b/%b expected %b/%b/%b",
                                     av, bv, ci, sb, s, c, o, es[1:0], ec, eo);
                        end
                        compared++;
                    end
                end
            end
        end
    endtask

    // Scenario sequence; ends with the summary line.
    initial begin
        test_reset();
        test_add();
        test_add_wrap();
        test_sub();
        test_ignore_start();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive_w2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time bound so a stuck design cannot hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
